// File: rtl/fpu_taylor_srv.sv
// Operation server for the Taylor-series FPU sequencer: Num/Den share one multiplier, Sum owns the adder.
// Optional per-engine timeout watchdog is compiled in with `define FPU_TAYLOR_SRV_WDOG_EN.
module fpu_taylor_srv #(
  parameter int CExpLen  = 8,
  parameter int CMantLen = 28,
  parameter int CWdogLen = 64,
  localparam int CDataLen = 1 + CExpLen + CMantLen
) (
  input  logic                AClkH,
  input  logic                AResetH,
  input  logic                AClkHEn,
  input  logic [CDataLen-1:0] ANumDataS,
  input  logic [CDataLen-1:0] ANumDataU,
  input  logic                ANumReq,
  output logic [CDataLen-1:0] ANumDataR,
  output logic                ANumAck,
  input  logic [CDataLen-1:0] ADenDataS,
  input  logic [CDataLen-1:0] ADenDataU,
  input  logic                ADenReq,
  output logic [CDataLen-1:0] ADenDataR,
  output logic                ADenAck,
  input  logic [CDataLen-1:0] ASumDataS,
  input  logic [CDataLen-1:0] ASumDataU,
  input  logic                ASumReq,
  output logic [CDataLen-1:0] ASumDataR,
  output logic                ASumAck,
  output logic [CDataLen-1:0] AMulS,
  output logic [CDataLen-1:0] AMulU,
  output logic                AMulStart,
  input  logic [CDataLen-1:0] AMulRes,
  input  logic                AMulAck,
  output logic [CDataLen-1:0] AAddS,
  output logic [CDataLen-1:0] AAddU,
  output logic                AAddStart,
  input  logic [CDataLen-1:0] AAddRes,
  input  logic                AAddAck,
  output logic                AOvf,
  output logic                AWdogErr
);

  typedef enum logic {GntNum = 1'b0, GntDen = 1'b1} gnt_e;

  logic                num_vld_q, den_vld_q, sum_vld_q;
  logic                num_vld_d, den_vld_d, sum_vld_d;
  logic [CDataLen-1:0] num_s_q, num_u_q, den_s_q, den_u_q, sum_s_q, sum_u_q;
  logic [CDataLen-1:0] num_r_q, den_r_q, sum_r_q;
  logic                num_ack_q, den_ack_q, sum_ack_q;
  logic                mul_busy_q, mul_busy_d, mul_start_q;
  gnt_e                mul_gnt_q, mul_gnt_d;
  logic                add_busy_q, add_busy_d, add_start_q;
  logic                ovf_q, ovf_set;

  logic                mul_take, add_take, mul_to, add_to, mul_done, add_done;
  logic                num_free, den_free, sum_free;
  logic                num_acc, den_acc, sum_acc;
  logic                mul_free, num_cand, den_cand, mul_issue, add_issue;
  logic [CDataLen-1:0] mul_res, add_res;

  // An engine ack only counts while an op is in flight; strays after reset or abort fall through.
  always_comb begin
    mul_take  = AMulAck & mul_busy_q;
    add_take  = AAddAck & add_busy_q;
    mul_done  = mul_take | mul_to;
    add_done  = add_take | add_to;
    mul_res   = mul_to ? '0 : AMulRes;
    add_res   = add_to ? '0 : AAddRes;
    num_free  = mul_done & (mul_gnt_q == GntNum);
    den_free  = mul_done & (mul_gnt_q == GntDen);
    sum_free  = add_done;
    num_acc   = ANumReq & (~num_vld_q | num_free);
    den_acc   = ADenReq & (~den_vld_q | den_free);
    sum_acc   = ASumReq & (~sum_vld_q | sum_free);
    num_vld_d = num_acc | (num_vld_q & ~num_free);
    den_vld_d = den_acc | (den_vld_q & ~den_free);
    sum_vld_d = sum_acc | (sum_vld_q & ~sum_free);
    ovf_set   = (ANumReq & ~num_acc) | (ADenReq & ~den_acc) | (ASumReq & ~sum_acc);

    // Round-robin: on a tie the channel granted last time yields.
    mul_free  = ~mul_busy_q | mul_done;
    num_cand  = num_vld_d & mul_free;
    den_cand  = den_vld_d & mul_free;
    mul_issue = num_cand | den_cand;
    mul_gnt_d = mul_gnt_q;
    if (den_cand && (!num_cand || mul_gnt_q == GntNum)) begin
      mul_gnt_d = GntDen;
    end else if (num_cand) begin
      mul_gnt_d = GntNum;
    end
    mul_busy_d = mul_issue | (mul_busy_q & ~mul_done);
    add_issue  = sum_vld_d & (~add_busy_q | add_done);
    add_busy_d = add_issue | (add_busy_q & ~add_done);
  end

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      num_vld_q   <= 1'b0;
      den_vld_q   <= 1'b0;
      sum_vld_q   <= 1'b0;
      num_s_q     <= '0;
      num_u_q     <= '0;
      den_s_q     <= '0;
      den_u_q     <= '0;
      sum_s_q     <= '0;
      sum_u_q     <= '0;
      num_r_q     <= '0;
      den_r_q     <= '0;
      sum_r_q     <= '0;
      num_ack_q   <= 1'b0;
      den_ack_q   <= 1'b0;
      sum_ack_q   <= 1'b0;
      mul_busy_q  <= 1'b0;
      mul_start_q <= 1'b0;
      mul_gnt_q   <= GntDen;
      add_busy_q  <= 1'b0;
      add_start_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (AClkHEn) begin
      num_vld_q <= num_vld_d;
      den_vld_q <= den_vld_d;
      sum_vld_q <= sum_vld_d;
      if (num_acc) begin
        num_s_q <= ANumDataS;
        num_u_q <= ANumDataU;
      end
      if (den_acc) begin
        den_s_q <= ADenDataS;
        den_u_q <= ADenDataU;
      end
      if (sum_acc) begin
        sum_s_q <= ASumDataS;
        sum_u_q <= ASumDataU;
      end
      if (num_free) num_r_q <= mul_res;
      if (den_free) den_r_q <= mul_res;
      if (sum_free) sum_r_q <= add_res;
      num_ack_q   <= num_free;
      den_ack_q   <= den_free;
      sum_ack_q   <= sum_free;
      mul_busy_q  <= mul_busy_d;
      mul_gnt_q   <= mul_gnt_d;
      mul_start_q <= mul_issue;
      add_busy_q  <= add_busy_d;
      add_start_q <= add_issue;
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

`ifdef FPU_TAYLOR_SRV_WDOG_EN
  localparam int CWdogW = $clog2(CWdogLen + 1);
  logic [CWdogW-1:0] mul_wd_q, add_wd_q;
  logic              wdog_err_q;

  // Counter is zero in the start cycle, so the abort lands on the CWdogLen-th cycle of flight.
  assign mul_to = mul_busy_q & ~mul_take & (mul_wd_q == CWdogW'(CWdogLen - 1));
  assign add_to = add_busy_q & ~add_take & (add_wd_q == CWdogW'(CWdogLen - 1));

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      mul_wd_q   <= '0;
      add_wd_q   <= '0;
      wdog_err_q <= 1'b0;
    end else if (AClkHEn) begin
      if (mul_issue)       mul_wd_q <= '0;
      else if (mul_busy_q) mul_wd_q <= mul_wd_q + CWdogW'(1);
      if (add_issue)       add_wd_q <= '0;
      else if (add_busy_q) add_wd_q <= add_wd_q + CWdogW'(1);
      if (mul_to || add_to) wdog_err_q <= 1'b1;
    end
  end

  assign AWdogErr = wdog_err_q;
`else
  assign mul_to   = 1'b0;
  assign add_to   = 1'b0;
  assign AWdogErr = 1'b0;
`endif

  // Engine operands come straight from the granted slot, which is held until the engine acks.
  assign AMulS     = (mul_gnt_q == GntDen) ? den_s_q : num_s_q;
  assign AMulU     = (mul_gnt_q == GntDen) ? den_u_q : num_u_q;
  assign AMulStart = mul_start_q;
  assign AAddS     = sum_s_q;
  assign AAddU     = sum_u_q;
  assign AAddStart = add_start_q;
  assign ANumDataR = num_r_q;
  assign ANumAck   = num_ack_q;
  assign ADenDataR = den_r_q;
  assign ADenAck   = den_ack_q;
  assign ASumDataR = sum_r_q;
  assign ASumAck   = sum_ack_q;
  assign AOvf      = ovf_q;

endmodule

// File: tb/tb_fpu_taylor_srv.sv
// Scoreboard bench for fpu_taylor_srv with behavioural multiplier/adder engines of programmable latency.
module tb_fpu_taylor_srv;
  localparam int CExpLen  = 8;
  localparam int CMantLen = 28;
  localparam int CD       = 1 + CExpLen + CMantLen;
  typedef logic [CD-1:0] data_t;

  localparam data_t F1 = {1'b0, 8'd127, 28'd0};
  localparam data_t F2 = {1'b0, 8'd128, 28'd0};
  localparam data_t F3 = {1'b0, 8'd128, 28'h8000000};
  localparam data_t F6 = {1'b0, 8'd129, 28'h8000000};

  logic  clk = 1'b0;
  always #5 clk = ~clk;

  logic  AResetH, AClkHEn;
  data_t ANumDataS, ANumDataU, ADenDataS, ADenDataU, ASumDataS, ASumDataU;
  logic  ANumReq, ADenReq, ASumReq;
  data_t ANumDataR, ADenDataR, ASumDataR;
  logic  ANumAck, ADenAck, ASumAck;
  data_t AMulS, AMulU, AMulRes, AAddS, AAddU, AAddRes;
  logic  AMulStart, AMulAck, AAddStart, AAddAck, AOvf, AWdogErr;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  data_t exp_num[$], exp_den[$], exp_sum[$];
  data_t mon_e;
  int num_acks = 0, den_acks = 0, sum_acks = 0, mul_starts = 0;
  int mul_lat = 3, add_lat = 1;

  fpu_taylor_srv #(.CExpLen(CExpLen), .CMantLen(CMantLen), .CWdogLen(64)) dut (
    .AClkH(clk), .AResetH(AResetH), .AClkHEn(AClkHEn),
    .ANumDataS(ANumDataS), .ANumDataU(ANumDataU), .ANumReq(ANumReq),
    .ANumDataR(ANumDataR), .ANumAck(ANumAck),
    .ADenDataS(ADenDataS), .ADenDataU(ADenDataU), .ADenReq(ADenReq),
    .ADenDataR(ADenDataR), .ADenAck(ADenAck),
    .ASumDataS(ASumDataS), .ASumDataU(ASumDataU), .ASumReq(ASumReq),
    .ASumDataR(ASumDataR), .ASumAck(ASumAck),
    .AMulS(AMulS), .AMulU(AMulU), .AMulStart(AMulStart), .AMulRes(AMulRes), .AMulAck(AMulAck),
    .AAddS(AAddS), .AAddU(AAddU), .AAddStart(AAddStart), .AAddRes(AAddRes), .AAddAck(AAddAck),
    .AOvf(AOvf), .AWdogErr(AWdogErr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Truncating float multiply for normal operands; exact for the 2.0 * 3.0 case.
  function automatic data_t f_mul(data_t s, data_t u);
    logic [CMantLen:0]       ms, mu;
    logic [2*CMantLen+1:0]   p;
    logic [CExpLen-1:0]      e;
    ms = {1'b1, s[CMantLen-1:0]};
    mu = {1'b1, u[CMantLen-1:0]};
    p  = ms * mu;
    e  = s[CD-2 -: CExpLen] + u[CD-2 -: CExpLen] - 8'd127;
    if (p[2*CMantLen+1]) return {s[CD-1] ^ u[CD-1], e + 8'd1, p[2*CMantLen -: CMantLen]};
    return {s[CD-1] ^ u[CD-1], e, p[2*CMantLen-1 -: CMantLen]};
  endfunction

  function automatic data_t f_add(data_t s, data_t u);
    return s + u;
  endfunction

  function automatic data_t rnd();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[CD-1:0];
  endfunction

  // Multiplier engine: result appears mul_lat cycles after the start cycle.
  initial begin
    data_t res;
    int    cnt;
    cnt = 0; res = '0; AMulAck = 1'b0; AMulRes = '0;
    forever begin
      @(posedge clk); #1;
      AMulAck = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin AMulAck = 1'b1; AMulRes = res; end
      end
      if (AMulStart === 1'b1) begin
        mul_starts++;
        cnt = mul_lat;
        res = f_mul(AMulS, AMulU);
      end
    end
  end

  initial begin
    data_t res;
    int    cnt;
    cnt = 0; res = '0; AAddAck = 1'b0; AAddRes = '0;
    forever begin
      @(posedge clk); #1;
      AAddAck = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin AAddAck = 1'b1; AAddRes = res; end
      end
      if (AAddStart === 1'b1) begin
        cnt = add_lat;
        res = f_add(AAddS, AAddU);
      end
    end
  end

  // Scoreboard: every channel ack must match the oldest expected result of that channel.
  always @(negedge clk) begin
    if (ANumAck === 1'b1) begin
      num_acks++; n_vec++;
      if (exp_num.size() == 0) begin
        n_err++; $display("FAIL num_ack_unexpected: got ack DataR=%h, required no ack", ANumDataR);
      end else begin
        mon_e = exp_num.pop_front();
        if (ANumDataR !== mon_e) begin
          n_err++; $display("FAIL num_result: got %h, required %h", ANumDataR, mon_e);
        end
      end
    end
    if (ADenAck === 1'b1) begin
      den_acks++; n_vec++;
      if (exp_den.size() == 0) begin
        n_err++; $display("FAIL den_ack_unexpected: got ack DataR=%h, required no ack", ADenDataR);
      end else begin
        mon_e = exp_den.pop_front();
        if (ADenDataR !== mon_e) begin
          n_err++; $display("FAIL den_result: got %h, required %h", ADenDataR, mon_e);
        end
      end
    end
    if (ASumAck === 1'b1) begin
      sum_acks++; n_vec++;
      if (exp_sum.size() == 0) begin
        n_err++; $display("FAIL sum_ack_unexpected: got ack DataR=%h, required no ack", ASumDataR);
      end else begin
        mon_e = exp_sum.pop_front();
        if (ASumDataR !== mon_e) begin
          n_err++; $display("FAIL sum_result: got %h, required %h", ASumDataR, mon_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    AResetH = 1'b1;
    tick(); tick();
    AResetH = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (exp_num.size() == 0 && exp_den.size() == 0 && exp_sum.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick(); tick();
  endtask

  task automatic wait_mul_start(output int c, output data_t s, output data_t u);
    bit found;
    found = 1'b0; c = -1; s = '0; u = '0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (AMulStart === 1'b1) begin
        found = 1'b1; c = cyc; s = AMulS; u = AMulU;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_vec++;
    if ({ANumAck, ADenAck, ASumAck, AMulStart, AAddStart, AOvf, AWdogErr} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b, required 0000000",
                        {ANumAck, ADenAck, ASumAck, AMulStart, AAddStart, AOvf, AWdogErr});
    end
    n_vec++;
    if (ANumDataR !== '0) begin n_err++; $display("FAIL reset_num_r: got %h, required 0", ANumDataR); end
    n_vec++;
    if (ADenDataR !== '0) begin n_err++; $display("FAIL reset_den_r: got %h, required 0", ADenDataR); end
    n_vec++;
    if (ASumDataR !== '0) begin n_err++; $display("FAIL reset_sum_r: got %h, required 0", ASumDataR); end
    tick();
  endtask

  task automatic test_num_latency();
    int t;
    bit ok;
    mul_lat = 3;
    t = cyc;
    ANumReq = 1'b1; ANumDataS = F2; ANumDataU = F3;
    exp_num.push_back(F6);
    @(negedge clk);
    n_vec++;
    if (AMulStart !== 1'b0) begin n_err++; $display("FAIL lat_no_bypass: got start %b, required 0", AMulStart); end
    tick();
    ANumReq = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({AMulStart, AMulS, AMulU} !== {1'b1, F2, F3}) begin
      n_err++; $display("FAIL lat_start: got %b %h %h, required 1 %h %h", AMulStart, AMulS, AMulU, F2, F3);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({AMulStart, AMulS} !== {1'b0, F2}) begin
      n_err++; $display("FAIL lat_start_pulse: got %b %h, required 0 %h", AMulStart, AMulS, F2);
    end
    while (cyc < t + 4) tick();
    @(negedge clk);
    n_vec++;
    if (ANumAck !== 1'b0) begin n_err++; $display("FAIL lat_early_ack: got %b, required 0", ANumAck); end
    tick();
    @(negedge clk);
    n_vec++;
    if ({ANumAck, ANumDataR} !== {1'b1, F6}) begin
      n_err++; $display("FAIL lat_ack: got %b %h, required 1 %h", ANumAck, ANumDataR, F6);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({ANumAck, ANumDataR} !== {1'b0, F6}) begin
      n_err++; $display("FAIL lat_ack_hold: got %b %h, required 0 %h", ANumAck, ANumDataR, F6);
    end
    tick();
    drain(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL lat_drain: got timeout, required empty scoreboard"); end
  endtask

  task automatic test_round_robin();
    int    t, c;
    bit    ok;
    data_t s, u, n1s, n1u, d1s, d1u, n2s, n2u;
    do_reset();
    mul_lat = 2;
    n1s = rnd(); n1u = rnd(); d1s = rnd(); d1u = rnd(); n2s = rnd(); n2u = rnd();
    t = cyc;
    ANumReq = 1'b1; ANumDataS = n1s; ANumDataU = n1u;
    ADenReq = 1'b1; ADenDataS = d1s; ADenDataU = d1u;
    exp_num.push_back(f_mul(n1s, n1u));
    exp_den.push_back(f_mul(d1s, d1u));
    tick();
    ANumReq = 1'b0; ADenReq = 1'b0;
    wait_mul_start(c, s, u);
    n_vec++;
    if (c != t + 1 || s !== n1s) begin
      n_err++; $display("FAIL rr_first_num: got cyc %0d S=%h, required cyc %0d S=%h", c, s, t + 1, n1s);
    end
    while (cyc < t + 3) tick();
    ANumReq = 1'b1; ANumDataS = n2s; ANumDataU = n2u;
    exp_num.push_back(f_mul(n2s, n2u));
    tick();
    ANumReq = 1'b0;
    wait_mul_start(c, s, u);
    n_vec++;
    if (c != t + 4 || s !== d1s || u !== d1u) begin
      n_err++; $display("FAIL rr_second_den: got cyc %0d S=%h, required cyc %0d S=%h", c, s, t + 4, d1s);
    end
    wait_mul_start(c, s, u);
    n_vec++;
    if (c != t + 7 || s !== n2s) begin
      n_err++; $display("FAIL rr_third_num: got cyc %0d S=%h, required cyc %0d S=%h", c, s, t + 7, n2s);
    end
    drain(ok);
    n_vec++;
    if (!ok || AOvf !== 1'b0) begin
      n_err++; $display("FAIL rr_refill_clean: got drained=%b AOvf=%b, required 1 0", ok, AOvf);
    end
    n1s = rnd(); n1u = rnd(); d1s = rnd(); d1u = rnd();
    ANumReq = 1'b1; ANumDataS = n1s; ANumDataU = n1u;
    ADenReq = 1'b1; ADenDataS = d1s; ADenDataU = d1u;
    exp_num.push_back(f_mul(n1s, n1u));
    exp_den.push_back(f_mul(d1s, d1u));
    tick();
    ANumReq = 1'b0; ADenReq = 1'b0;
    wait_mul_start(c, s, u);
    n_vec++;
    if (s !== d1s) begin n_err++; $display("FAIL rr_tie_den: got S=%h, required %h", s, d1s); end
    wait_mul_start(c, s, u);
    n_vec++;
    if (s !== n1s) begin n_err++; $display("FAIL rr_tie_num: got S=%h, required %h", s, n1s); end
    drain(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL rr_drain: got timeout, required empty scoreboard"); end
  endtask

  task automatic test_sum_chain();
    int    t;
    bit    ok;
    data_t ds, du, dr, ns, nu, ss, su;
    mul_lat = 2; add_lat = 2;
    ds = rnd(); du = rnd(); dr = f_mul(ds, du);
    t = cyc;
    ADenReq = 1'b1; ADenDataS = ds; ADenDataU = du;
    exp_den.push_back(dr);
    tick();
    ADenReq = 1'b0;
    while (cyc < t + 4) tick();
    ASumReq = 1'b1; ASumDataS = dr; ASumDataU = F1;
    exp_sum.push_back(f_add(dr, F1));
    @(negedge clk);
    n_vec++;
    if (ADenAck !== 1'b1) begin n_err++; $display("FAIL chain_den_ack: got %b, required 1", ADenAck); end
    tick();
    ASumReq = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({AAddStart, AAddS, AAddU} !== {1'b1, dr, F1}) begin
      n_err++; $display("FAIL chain_add_start: got %b %h %h, required 1 %h %h", AAddStart, AAddS, AAddU, dr, F1);
    end
    tick();
    drain(ok);
    mul_lat = 3; add_lat = 3;
    ns = rnd(); nu = rnd(); ss = rnd(); su = rnd();
    t = cyc;
    ANumReq = 1'b1; ANumDataS = ns; ANumDataU = nu;
    ASumReq = 1'b1; ASumDataS = ss; ASumDataU = su;
    exp_num.push_back(f_mul(ns, nu));
    exp_sum.push_back(f_add(ss, su));
    tick();
    ANumReq = 1'b0; ASumReq = 1'b0;
    while (cyc < t + 5) tick();
    @(negedge clk);
    n_vec++;
    if ({ANumAck, ASumAck} !== 2'b11) begin
      n_err++; $display("FAIL concurrent_acks: got %b, required 11", {ANumAck, ASumAck});
    end
    tick();
    drain(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL chain_drain: got timeout, required empty scoreboard"); end
  endtask

  task automatic test_overflow();
    int    a0;
    bit    ok;
    data_t as, au;
    mul_lat = 4;
    as = rnd(); au = rnd();
    a0 = num_acks;
    ANumReq = 1'b1; ANumDataS = as; ANumDataU = au;
    exp_num.push_back(f_mul(as, au));
    tick();
    ANumDataS = rnd(); ANumDataU = rnd();
    tick();
    ANumReq = 1'b0;
    @(negedge clk);
    n_vec++;
    if (AOvf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b, required 1", AOvf); end
    n_vec++;
    if ({AMulS, AMulU} !== {as, au}) begin
      n_err++; $display("FAIL ovf_operands: got %h %h, required %h %h", AMulS, AMulU, as, au);
    end
    tick();
    drain(ok);
    n_vec++;
    if (!ok || num_acks - a0 != 1) begin
      n_err++; $display("FAIL ovf_single_ack: got %0d acks drained=%b, required 1 ack", num_acks - a0, ok);
    end
  endtask

  task automatic test_midop_reset();
    int    c, a0, s0;
    data_t s, u;
    mul_lat = 5;
    ANumReq = 1'b1; ANumDataS = rnd(); ANumDataU = rnd();
    tick();
    ANumReq = 1'b0;
    wait_mul_start(c, s, u);
    n_vec++;
    if (c < 0) begin n_err++; $display("FAIL rst_start_seen: got no start, required a start"); end
    AResetH = 1'b1;
    tick();
    AResetH = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({ANumAck, AMulStart, AOvf, ANumDataR} !== {3'b000, {CD{1'b0}}}) begin
      n_err++; $display("FAIL rst_midop_state: got %b%b%b %h, required 000 0", ANumAck, AMulStart, AOvf, ANumDataR);
    end
    tick();
    a0 = num_acks; s0 = mul_starts;
    repeat (10) tick();
    n_vec++;
    if (num_acks != a0 || mul_starts != s0 || ANumDataR !== '0) begin
      n_err++; $display("FAIL rst_stray_ack: got acks %0d starts %0d DataR %h, required 0 0 0",
                        num_acks - a0, mul_starts - s0, ANumDataR);
    end
  endtask

  task automatic test_enable();
    int a0, s0;
    a0 = num_acks; s0 = mul_starts;
    AClkHEn = 1'b0;
    ANumReq = 1'b1; ANumDataS = rnd(); ANumDataU = rnd();
    tick();
    ANumReq = 1'b0;
    tick(); tick();
    AClkHEn = 1'b1;
    repeat (10) tick();
    n_vec++;
    if (num_acks != a0 || mul_starts != s0) begin
      n_err++; $display("FAIL enable_hold: got acks %0d starts %0d, required 0 0", num_acks - a0, mul_starts - s0);
    end
  endtask

  task automatic test_back_to_back();
    int    rn, rd, rs, a0n, a0d, a0s;
    bit    ok;
    data_t s, u;
    rn = 0; rd = 0; rs = 0;
    a0n = num_acks; a0d = den_acks; a0s = sum_acks;
    for (int i = 0; i < 200; i++) begin
      mul_lat = $urandom_range(1, 4);
      add_lat = $urandom_range(1, 4);
      if (exp_num.size() == 0 && $urandom_range(0, 2) == 0) begin
        s = rnd(); u = rnd();
        ANumReq = 1'b1; ANumDataS = s; ANumDataU = u;
        exp_num.push_back(f_mul(s, u)); rn++;
      end
      if (exp_den.size() == 0 && $urandom_range(0, 2) == 0) begin
        s = rnd(); u = rnd();
        ADenReq = 1'b1; ADenDataS = s; ADenDataU = u;
        exp_den.push_back(f_mul(s, u)); rd++;
      end
      if (exp_sum.size() == 0 && $urandom_range(0, 2) == 0) begin
        s = rnd(); u = rnd();
        ASumReq = 1'b1; ASumDataS = s; ASumDataU = u;
        exp_sum.push_back(f_add(s, u)); rs++;
      end
      tick();
      ANumReq = 1'b0; ADenReq = 1'b0; ASumReq = 1'b0;
    end
    drain(ok);
    n_vec++;
    if (!ok || num_acks - a0n != rn || den_acks - a0d != rd || sum_acks - a0s != rs) begin
      n_err++; $display("FAIL b2b_counts: got %0d/%0d/%0d acks, required %0d/%0d/%0d",
                        num_acks - a0n, den_acks - a0d, sum_acks - a0s, rn, rd, rs);
    end
    n_vec++;
    if (AOvf !== 1'b0) begin n_err++; $display("FAIL b2b_no_ovf: got %b, required 0", AOvf); end
  endtask

  initial begin
    AResetH = 1'b1; AClkHEn = 1'b1;
    ANumReq = 1'b0; ADenReq = 1'b0; ASumReq = 1'b0;
    ANumDataS = '0; ANumDataU = '0; ADenDataS = '0; ADenDataU = '0; ASumDataS = '0; ASumDataU = '0;
    test_reset();
    test_num_latency();
    test_round_robin();
    test_sum_chain();
    test_overflow();
    test_midop_reset();
    test_enable();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no completion, required finish before time limit");
    $fatal(1, "timeout");
  end
endmodule
